rob_retire_unit: RTL and testbench
==================================

# rob_retire_unit

In-order retirement engine for the out-of-order datapath. It reads the reorder-buffer head entry, retires completed entries one per cycle into the architectural register file and flag register, and pops the ROB head. It also clears the map-table entry for a retired destination if no younger instruction has renamed that register since. It sits after the completion stage, on the read side of the ROB commit port that completion writes.

## Interface
Parameters:
- ROBsize, 32, number of ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), ROB tag width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-low.
- ROBhead_i  in  ROBsizeLog  current head tag.
- ROBcommitReadData_i  in  78  head entry, layout per package.
- ROBupdateHead_o  out  1  pop head this cycle.
- hold_i  in  1  suppress retirement (debug/drain).
- mapCommitReadAddr_o  out  5  map-table lookup register.
- mapCommitReadData_i  in  ROBsizeLog  tag currently mapped to that register.
- mapResets_o  out  32  one-hot map-entry clear.
- WriteRegister_o  out  5  regfile write address.
- WriteData_o  out  64  regfile write data.
- RegWrite_o  out  1  regfile write enable.
- archFlags_o  out  4  architectural NZVC flags.
- retiredTag_o  out  ROBsizeLog  tag retired last cycle.
- retireValid_o  out  1  retire-stage register holds a retirement.

## Operation
- ROB entry fields: value[63:0], done[64], flags[68:65], saveFlags[69], destReg[74:70], regWrite[75], valid[76], spare[77].
- Stage R0 is combinational. canRetire = valid & done & ~hold_i. ROBupdateHead_o = canRetire.
- Stage R1 is a register loaded when canRetire. It holds tag = ROBhead_i, destReg, value, regWrite, saveFlags and flags. Otherwise R1.valid clears.
- While R1 is valid:
  - RegWrite_o = R1.regWrite & (R1.destReg != 31). Register 31 is the zero register; writes to it are dropped.
  - WriteRegister_o and WriteData_o come from R1.
- mapCommitReadAddr_o = R1.destReg.
  - mapResets_o[R1.destReg] = 1 only if R1.valid & R1.regWrite & (mapCommitReadData_i == R1.tag). All other bits are 0.
  - A younger rename leaves the map entry intact.
- archFlags_o is a register. It loads R1.flags on the edge ending an R1 cycle with saveFlags set.
- retiredTag_o = R1.tag; retireValid_o = R1.valid.

## Timing
- Reset values: ROBupdateHead_o 0, R1 cleared, RegWrite_o 0, mapResets_o 0, WriteRegister_o 0, WriteData_o 0, archFlags_o 0, retiredTag_o 0, retireValid_o 0.
- Latency from head pop to regfile write and map clear is 1 cycle. Sustained throughput is 1 retirement per cycle.
- Back-to-back retirements to the same register:
  - Both regfile writes occur in order.
  - The map clear fires only for the tag still mapped.
- Map-table conflict: if decode writes the same map entry in the R1 cycle, decode has priority inside the map table. The comparison uses the pre-write map value.
- hold_i takes effect the same cycle. An R1 already loaded still completes.
- Empty ROB (valid = 0) produces no pop and no writes.
- ROB head wrap-around is owned by the ROB. This block uses the tag as given.
- Reset asserted mid-operation clears R1 immediately. The pending write is lost by design.

## Configuration
- RETIRE_STATS_EN, when defined, adds two outputs:
  - retiredCount_o (32 b): increments on each canRetire.
  - stallCount_o (32 b): increments each cycle with valid & ~done.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, neither port nor counter exists.

## Structure
- The shared package holds:
  - the ROB commit-entry packed struct (78 b, fields above),
  - the zero-register constant 31,
  - the flag index constants.
- One sub-module, retire_stats_counter, is instantiated twice under RETIRE_STATS_EN.

## Test plan
- Reset release, head entry valid=0 -> ROBupdateHead_o 0, all outputs 0 for 10 cycles.
- Head tag 5 entry {valid, done, regWrite, destReg=3, value=0xDEAD}, map[3]=5 -> pop at cycle N. At N+1: RegWrite_o=1, WriteRegister_o=3, WriteData_o=0xDEAD, mapResets_o=0x8.
- Same entry but map[3]=9 (younger rename) -> regfile write occurs, mapResets_o=0.
- Entry valid but done=0 for 4 cycles, then done=1 -> no pop for 4 cycles, pop on the 5th.
- destReg=31 with saveFlags=1, flags=0b1010 -> RegWrite_o=0; archFlags_o=0b1010 after the R1 cycle.
- Three consecutive ready entries with hold_i asserted on the second cycle -> first retires, second waits, both remaining retire in order once hold_i drops.

Source files
------------

// File: rtl/rob_retire_unit_pkg.sv
// Shared types and constants for the in-order ROB retirement engine:
// the 78-bit ROB commit-entry layout, the zero register and NZVC flag indices.
package rob_retire_unit_pkg;

  localparam int ENTRY_W = 78;
  localparam logic [4:0] ZERO_REG = 5'd31;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Field order mirrors the entry bit layout, MSB first.
  typedef struct packed {
    logic        spare;
    logic        valid;
    logic        regWrite;
    logic [4:0]  destReg;
    logic        saveFlags;
    logic [3:0]  flags;
    logic        done;
    logic [63:0] value;
  } robEntry_t;

  function automatic logic [31:0] regOneHot(input logic [4:0] r);
    regOneHot = 32'd1 << r;
  endfunction

endpackage

// File: rtl/rob_retire_unit_if.sv
// ROB commit-port read side and map-table commit port seen by the retire unit.
// Valid/ready: ROBupdateHead is asserted only while the head entry is valid, done and not held; the ROB pops on that cycle's edge.
interface rob_retire_unit_if #(
  parameter int ROBsizeLog = 6
);
  import rob_retire_unit_pkg::*;

  logic [ROBsizeLog-1:0] ROBhead;
  robEntry_t             ROBcommitReadData;
  logic                  ROBupdateHead;
  logic [4:0]            mapCommitReadAddr;
  logic [ROBsizeLog-1:0] mapCommitReadData;
  logic [31:0]           mapResets;

  // ROB / map-table side
  modport master (
    output ROBhead, ROBcommitReadData, mapCommitReadData,
    input  ROBupdateHead, mapCommitReadAddr, mapResets
  );

  // Retire unit side
  modport slave (
    input  ROBhead, ROBcommitReadData, mapCommitReadData,
    output ROBupdateHead, mapCommitReadAddr, mapResets
  );
endinterface

// File: rtl/rob_retire_unit_stats.sv
// Saturating 32-bit event counter used for the optional retirement statistics
// (only instantiated when RETIRE_STATS_EN is defined).
module retire_stats_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {W{1'b1}})) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/rob_retire_unit.sv
// In-order retirement engine: pops completed ROB head entries, writes the register file
// and flags one cycle later, and clears stale map entries. Optional counters: RETIRE_STATS_EN.
module rob_retire_unit
  import rob_retire_unit_pkg::*;
#(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  hold_i,
  rob_retire_unit_if.slave      robIf,
  output logic [4:0]            WriteRegister_o,
  output logic [63:0]           WriteData_o,
  output logic                  RegWrite_o,
  output logic [3:0]            archFlags_o,
  output logic [ROBsizeLog-1:0] retiredTag_o,
  output logic                  retireValid_o
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]           retiredCount_o,
  output logic [31:0]           stallCount_o
`endif
);

  logic canRetire;

  logic                  r1Valid;
  logic [ROBsizeLog-1:0] r1Tag;
  logic [4:0]            r1DestReg;
  logic [63:0]           r1Value;
  logic                  r1RegWrite;
  logic                  r1SaveFlags;
  logic [3:0]            r1Flags;
  logic                  mapStillOurs;

  // Stage R0: purely combinational head inspection.
  assign canRetire           = robIf.ROBcommitReadData.valid
                             & robIf.ROBcommitReadData.done
                             & ~hold_i;
  assign robIf.ROBupdateHead = canRetire;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r1Valid     <= 1'b0;
      r1Tag       <= '0;
      r1DestReg   <= '0;
      r1Value     <= '0;
      r1RegWrite  <= 1'b0;
      r1SaveFlags <= 1'b0;
      r1Flags     <= '0;
      archFlags_o <= '0;
    end else begin
      r1Valid <= canRetire;
      if (canRetire) begin
        r1Tag       <= robIf.ROBhead;
        r1DestReg   <= robIf.ROBcommitReadData.destReg;
        r1Value     <= robIf.ROBcommitReadData.value;
        r1RegWrite  <= robIf.ROBcommitReadData.regWrite;
        r1SaveFlags <= robIf.ROBcommitReadData.saveFlags;
        r1Flags     <= robIf.ROBcommitReadData.flags;
      end
      if (r1Valid && r1SaveFlags) begin
        archFlags_o <= r1Flags;
      end
    end
  end

  // Stage R1 outputs. Data/address are zeroed when R1 is empty so the regfile port idles cleanly.
  always_comb begin
    RegWrite_o      = 1'b0;
    WriteRegister_o = '0;
    WriteData_o     = '0;
    if (r1Valid) begin
      RegWrite_o      = r1RegWrite & (r1DestReg != ZERO_REG);
      WriteRegister_o = r1DestReg;
      WriteData_o     = r1Value;
    end
  end

  // The map entry is only cleared if no younger instruction has renamed the register;
  // the comparison sees the map value from before any same-cycle decode write.
  assign robIf.mapCommitReadAddr = r1DestReg;
  assign mapStillOurs            = (robIf.mapCommitReadData == r1Tag);

  always_comb begin
    robIf.mapResets = '0;
    if (r1Valid && r1RegWrite && mapStillOurs) begin
      robIf.mapResets = regOneHot(r1DestReg);
    end
  end

  assign retiredTag_o  = r1Tag;
  assign retireValid_o = r1Valid;

`ifdef RETIRE_STATS_EN
  logic headStalled;
  assign headStalled = robIf.ROBcommitReadData.valid & ~robIf.ROBcommitReadData.done;

  retire_stats_counter #(.W(32)) u_retiredCount (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (canRetire),
    .count_o (retiredCount_o)
  );

  retire_stats_counter #(.W(32)) u_stallCount (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (headStalled),
    .count_o (stallCount_o)
  );
`endif

endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed bench for rob_retire_unit: a table of single-entry retirements plus
// hand-written multi-cycle sequences (stall, hold, back-to-back, mid-run reset).
module tb_rob_retire_unit;
  import rob_retire_unit_pkg::*;

  localparam int TW = 6;

  logic clk_i = 1'b0;
  logic reset_i;
  logic hold_i;
  logic [4:0]    WriteRegister_o;
  logic [63:0]   WriteData_o;
  logic          RegWrite_o;
  logic [3:0]    archFlags_o;
  logic [TW-1:0] retiredTag_o;
  logic          retireValid_o;
`ifdef RETIRE_STATS_EN
  logic [31:0] retiredCount_o;
  logic [31:0] stallCount_o;
`endif

  logic [TW-1:0] mapTable [32];

  int errors = 0;
  int checks = 0;

  rob_retire_unit_if #(.ROBsizeLog(TW)) rif ();

  assign rif.mapCommitReadData = mapTable[rif.mapCommitReadAddr];

  rob_retire_unit #(.ROBsize(32)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .hold_i          (hold_i),
    .robIf           (rif),
    .WriteRegister_o (WriteRegister_o),
    .WriteData_o     (WriteData_o),
    .RegWrite_o      (RegWrite_o),
    .archFlags_o     (archFlags_o),
    .retiredTag_o    (retiredTag_o),
    .retireValid_o   (retireValid_o)
`ifdef RETIRE_STATS_EN
    ,
    .retiredCount_o  (retiredCount_o),
    .stallCount_o    (stallCount_o)
`endif
  );

  // clock
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TW-1:0] tag;
    logic          valid;
    logic          done;
    logic          regWrite;
    logic [4:0]    destReg;
    logic          saveFlags;
    logic [3:0]    flags;
    logic [63:0]   value;
    logic          hold;
    logic [TW-1:0] mapVal;
    logic          expPop;
    logic          expRW;
    logic [4:0]    expWR;
    logic [63:0]   expWD;
    logic [31:0]   expMR;
    logic [3:0]    expFlags;
  } vec_t;

  vec_t vecs [9];

  function automatic robEntry_t mkEntry(input logic valid, input logic done, input logic regWrite,
                                        input logic [4:0] destReg, input logic saveFlags,
                                        input logic [3:0] flags, input logic [63:0] value);
    robEntry_t e;
    e.spare     = 1'b0;
    e.valid     = valid;
    e.regWrite  = regWrite;
    e.destReg   = destReg;
    e.saveFlags = saveFlags;
    e.flags     = flags;
    e.done      = done;
    e.value     = value;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [TW-1:0] tag, input robEntry_t e, input logic hold);
    rif.ROBhead           = tag;
    rif.ROBcommitReadData = e;
    hold_i                = hold;
  endtask

  task automatic driveIdle();
    drive('0, mkEntry(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 64'd0), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkAllZero(input string name);
    check(name, {rif.ROBupdateHead, RegWrite_o, rif.mapResets, WriteRegister_o, WriteData_o,
                 archFlags_o, retiredTag_o, retireValid_o}, '0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mapTable[r] = '0;

    //          tag  v  d  rw dst sv flags    value                  hold map  pop rw  wr    wd                     mr            flags
    vecs[0] = '{6'd5,  1, 1, 1, 5'd3,  0, 4'b0000, 64'hDEAD,              0, 6'd5,  1, 1, 5'd3,  64'hDEAD,              32'h8,        4'b0000};
    vecs[1] = '{6'd5,  1, 1, 1, 5'd3,  0, 4'b0000, 64'hDEAD,              0, 6'd9,  1, 1, 5'd3,  64'hDEAD,              32'h0,        4'b0000};
    vecs[2] = '{6'd7,  1, 1, 1, 5'd31, 1, 4'b1010, 64'h1234,              0, 6'd0,  1, 0, 5'd31, 64'h1234,              32'h0,        4'b1010};
    vecs[3] = '{6'd8,  1, 1, 0, 5'd4,  0, 4'b0000, 64'h55,                0, 6'd8,  1, 0, 5'd4,  64'h55,                32'h0,        4'b1010};
    vecs[4] = '{6'd9,  1, 1, 1, 5'd6,  1, 4'b0101, 64'h99,                1, 6'd9,  0, 0, 5'd0,  64'h0,                 32'h0,        4'b1010};
    vecs[5] = '{6'd12, 0, 1, 1, 5'd7,  1, 4'b0101, 64'h77,                0, 6'd12, 0, 0, 5'd0,  64'h0,                 32'h0,        4'b1010};
    vecs[6] = '{6'd13, 1, 0, 1, 5'd8,  1, 4'b0101, 64'h88,                0, 6'd13, 0, 0, 5'd0,  64'h0,                 32'h0,        4'b1010};
    vecs[7] = '{6'd32, 1, 1, 1, 5'd0,  0, 4'b0000, 64'hFFFFFFFFFFFFFFFF, 0, 6'd32, 1, 1, 5'd0,  64'hFFFFFFFFFFFFFFFF, 32'h1,        4'b1010};
    vecs[8] = '{6'd63, 1, 1, 1, 5'd30, 1, 4'b0000, 64'h77,                0, 6'd63, 1, 1, 5'd30, 64'h77,                32'h40000000, 4'b0000};

    // reset
    reset_i = 1'b0;
    driveIdle();
    #12;
    checkAllZero("reset_state");
    @(negedge clk_i);
    reset_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkAllZero($sformatf("empty_rob_c%0d", c));
    end

    // table-driven single retirements
    for (int i = 0; i < 9; i++) begin
      mapTable[vecs[i].destReg] = vecs[i].mapVal;
      drive(vecs[i].tag,
            mkEntry(vecs[i].valid, vecs[i].done, vecs[i].regWrite, vecs[i].destReg,
                    vecs[i].saveFlags, vecs[i].flags, vecs[i].value),
            vecs[i].hold);
      #1;
      check($sformatf("v%0d_pop", i), rif.ROBupdateHead, vecs[i].expPop);
      tick();
      driveIdle();
      #1;
      check($sformatf("v%0d_rv", i), retireValid_o, vecs[i].expPop);
      check($sformatf("v%0d_regwrite", i), RegWrite_o, vecs[i].expRW);
      check($sformatf("v%0d_wreg", i), WriteRegister_o, vecs[i].expWR);
      check($sformatf("v%0d_wdata", i), WriteData_o, vecs[i].expWD);
      check($sformatf("v%0d_mapresets", i), rif.mapResets, vecs[i].expMR);
      if (vecs[i].expPop) check($sformatf("v%0d_tag", i), retiredTag_o, vecs[i].tag);
      tick();
      check($sformatf("v%0d_flags", i), archFlags_o, vecs[i].expFlags);
      check($sformatf("v%0d_idle", i), {retireValid_o, RegWrite_o, rif.mapResets}, '0);
    end

    // head not done for 4 cycles, then done
    mapTable[5'd9] = 6'd20;
    for (int c = 0; c < 4; c++) begin
      drive(6'd20, mkEntry(1, 0, 1, 5'd9, 0, 4'd0, 64'hABC), 1'b0);
      #1;
      check($sformatf("stall_nopop_c%0d", c), rif.ROBupdateHead, 1'b0);
      tick();
      check($sformatf("stall_nowrite_c%0d", c), RegWrite_o, 1'b0);
    end
    drive(6'd20, mkEntry(1, 1, 1, 5'd9, 0, 4'd0, 64'hABC), 1'b0);
    #1;
    check("stall_pop5", rif.ROBupdateHead, 1'b1);
    tick();
    driveIdle();
    #1;
    check("stall_write", {RegWrite_o, WriteRegister_o, WriteData_o, rif.mapResets},
          {1'b1, 5'd9, 64'hABC, 32'h200});
    tick();

    // three ready entries, hold on the second cycle
    mapTable[5'd1] = 6'd40;
    mapTable[5'd2] = 6'd41;
    mapTable[5'd3] = 6'd42;
    drive(6'd40, mkEntry(1, 1, 1, 5'd1, 0, 4'd0, 64'h101), 1'b0);
    #1;
    check("hold_popA", rif.ROBupdateHead, 1'b1);
    tick();
    drive(6'd41, mkEntry(1, 1, 1, 5'd2, 0, 4'd0, 64'h102), 1'b1);
    #1;
    check("hold_nopopB", rif.ROBupdateHead, 1'b0);
    check("hold_retA", {retireValid_o, retiredTag_o, WriteData_o}, {1'b1, 6'd40, 64'h101});
    tick();
    hold_i = 1'b0;
    #1;
    check("hold_bubble", {retireValid_o, RegWrite_o}, 2'b00);
    check("hold_popB", rif.ROBupdateHead, 1'b1);
    tick();
    drive(6'd42, mkEntry(1, 1, 1, 5'd3, 0, 4'd0, 64'h103), 1'b0);
    #1;
    check("hold_popC", rif.ROBupdateHead, 1'b1);
    check("hold_retB", {retireValid_o, retiredTag_o, WriteData_o, rif.mapResets},
          {1'b1, 6'd41, 64'h102, 32'h4});
    tick();
    driveIdle();
    #1;
    check("hold_retC", {retireValid_o, retiredTag_o, WriteData_o, rif.mapResets},
          {1'b1, 6'd42, 64'h103, 32'h8});
    tick();
    check("hold_done", retireValid_o, 1'b0);

    // back-to-back retirements to the same register; younger tag owns the map entry
    mapTable[5'd2] = 6'd11;
    drive(6'd10, mkEntry(1, 1, 1, 5'd2, 0, 4'd0, 64'hA), 1'b0);
    tick();
    drive(6'd11, mkEntry(1, 1, 1, 5'd2, 0, 4'd0, 64'hB), 1'b0);
    #1;
    check("b2b_first", {RegWrite_o, WriteRegister_o, WriteData_o, rif.mapResets, retiredTag_o},
          {1'b1, 5'd2, 64'hA, 32'h0, 6'd10});
    tick();
    driveIdle();
    #1;
    check("b2b_second", {RegWrite_o, WriteRegister_o, WriteData_o, rif.mapResets, retiredTag_o},
          {1'b1, 5'd2, 64'hB, 32'h4, 6'd11});
    tick();

    // reset while R1 holds a retirement
    drive(6'd3, mkEntry(1, 1, 1, 5'd5, 1, 4'b1111, 64'h5A5A), 1'b0);
    tick();
    check("midreset_loaded", retireValid_o, 1'b1);
    driveIdle();
    #2;
    reset_i = 1'b0;
    #1;
    check("midreset_cleared", {retireValid_o, RegWrite_o, WriteData_o, retiredTag_o, archFlags_o}, '0);
    @(negedge clk_i);
    reset_i = 1'b1;
    tick();
    check("midreset_after", {retireValid_o, RegWrite_o, archFlags_o}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
